jtkcpu_idxctl: RTL and testbench
================================

JTKCPU_IDXCTL -- requirements
Module: jtkcpu_idxctl

Interface
REQ-001 SHALL have ports: rst in 1, asynchronous active-high reset; clk in 1, single clock.
REQ-002 cen in 1: clock enable; all state advances only on clk edges with cen=1.
REQ-003 start in 1: postbyte valid on din; accepted only in IDLE.
REQ-004 din in 8: postbyte at start; otherwise bus read data, valid one cen cycle after rd.
REQ-005 a, b in 8 each: accumulators; D={a,b}.
REQ-006 idx_reg in 16: value of the register chosen by idx_sel.
REQ-007 pc in 16: address of the byte after the postbyte, stable while busy.
REQ-008 idx_sel out 2: postbyte[6:5]; 0=X, 1=Y, 2=U, 3=S.
REQ-009 rd out 1; addr out 16: bus read request and address, registered.
REQ-010 pc_inc out 1: one cen-cycle pulse per extension byte consumed.
REQ-011 ea out 16: effective address, valid while done=1.
REQ-012 upd out 1; upd_val out 16: write-back of the selected register for auto inc/dec.
REQ-013 busy out 1; done out 1; bad out 1: sequence active; completion pulse; illegal-postbyte pulse.

Function
REQ-014 postbyte[7]=1 SHALL select a 5-bit offset: sign-extend postbyte[4:0]; no indirect; no extension bytes.
REQ-015 postbyte[7]=0 SHALL decode postbyte[4] as indirect and postbyte[3:0] as mode: 0 ,R+; 1 ,R++; 2 ,-R; 3 ,--R; 4 ,R; 5 B,R; 6 A,R; 8 n8,R; 9 n16,R; B D,R; C n8,PC; D n16,PC; F [n16] absolute (indirect forced).
REQ-016 Modes 7, A, E, and indirect with mode 0 or 2, SHALL pulse bad and done together, 2 cycles after start, with ea=0 and no upd.
REQ-017 States SHALL be IDLE, EXT_HI, EXT_LO, CALC, IND_HI, IND_LO, FIN; IDLE->EXT_HI (16-bit ext) | EXT_LO (8-bit ext) | CALC; EXT_HI->EXT_LO->CALC; CALC->IND_HI (indirect) | FIN; IND_HI->IND_LO->FIN; FIN->IDLE.
REQ-018 Each bus byte SHALL take 2 cen cycles: rd=1 with addr in the first, din captured in the second.
REQ-019 Extension bytes SHALL be read from pc, pc+1 (high byte first); pc_inc pulses when each byte is captured.
REQ-020 Latency start->done SHALL be 2 + 2*(extension bytes) + (indirect ? 4 : 0) cen cycles; done lasts one cen cycle.
REQ-021 8-bit offsets, A and B SHALL be sign-extended; D and n16 used as-is; all sums 16-bit modulo (wrap).
REQ-022 PC-relative base SHALL be pc + number of extension bytes.
REQ-023 Post-inc: ea=idx_reg, upd_val=idx_reg+1/2; pre-dec: ea=upd_val=idx_reg-1/2; upd pulses with done.
REQ-024 Indirect SHALL read 16-bit big-endian pointer at ea, ea+1; final ea = pointer.
REQ-025 busy SHALL be 1 from the cycle after start until done inclusive; start while busy ignored.
REQ-026 cen=0 SHALL freeze all state and hold outputs.

Reset
REQ-027 rst SHALL force IDLE, and rd, pc_inc, upd, busy, done, bad=0, and addr, ea, upd_val=0, at any time, aborting a sequence without done.

Structure
REQ-028 Mode codes and state encoding SHALL live in jtkcpu_pkg.
REQ-029 Offset decode SHALL be a combinational sub-module jtkcpu_idx_ofs.

Verification
REQ-030 pb=0xBF, Y=0x1000 -> no rd; ea=0x0FFF, done at start+2.
REQ-031 pb=0x08, X=0x2000, pc=0x0100, mem[0x0100]=0x80 -> rd addr 0x0100, one pc_inc, ea=0x1F80 at start+4.
REQ-032 pb=0x1F, mem[0x0100..0101]=0x12,0x34, mem[0x1234..1235]=0xAB,0xCD -> ea=0xABCD at start+10.
REQ-033 pb=0x41, U=0xFFFF -> ea=0xFFFF, upd=1, upd_val=0x0001 at start+2.
REQ-034 pb=0x07 -> bad and done at start+2; second start while busy ignored; rst during EXT_LO -> busy=0, no done.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
// jtkcpu_pkg: indexed-addressing mode codes, controller states and decode helpers
package jtkcpu_pkg;
    typedef enum logic [2:0] {IDLE, EXT_HI, EXT_LO, CALC, IND_HI, IND_LO, FIN} state_t;
    localparam logic [3:0] M_INC1 = 4'h0, M_INC2 = 4'h1, M_DEC1 = 4'h2, M_DEC2 = 4'h3,
                           M_ZERO = 4'h4, M_B    = 4'h5, M_A    = 4'h6, M_N8   = 4'h8,
                           M_N16  = 4'h9, M_D    = 4'hB, M_PC8  = 4'hC, M_PC16 = 4'hD,
                           M_EXT  = 4'hF;
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction
    function automatic logic [1:0] ext_len(input logic [7:0] pb);
        return pb[7] ? 2'd0 :
               (pb[3:0] == M_N8  || pb[3:0] == M_PC8)  ? 2'd1 :
               (pb[3:0] == M_N16 || pb[3:0] == M_PC16 || pb[3:0] == M_EXT) ? 2'd2 : 2'd0;
    endfunction
endpackage

// File: rtl/jtkcpu_idx_ofs.sv
// jtkcpu_idx_ofs: combinational postbyte decode into effective address and register write-back
module jtkcpu_idx_ofs
    import jtkcpu_pkg::*;
(
    input  logic [7:0]  pb,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] idx_reg,
    input  logic [15:0] pc,
    input  logic [15:0] ext,
    output logic [15:0] ea,
    output logic [15:0] upd_val,
    output logic        upd,
    output logic        ind,
    output logic        bad
);
    logic [3:0] mode;
    assign mode = pb[3:0];
    always_comb begin
        ea = '0;
        upd_val = '0;
        upd = 1'b0;
        ind = 1'b0;
        bad = 1'b0;
        if (pb[7]) ea = idx_reg + {{11{pb[4]}}, pb[4:0]};
        else if (pb[4] && (mode == M_INC1 || mode == M_DEC1)) bad = 1'b1;
        else begin
            ind = pb[4];
            case (mode)
                M_INC1: begin ea = idx_reg; upd_val = idx_reg + 16'd1; upd = 1'b1; end
                M_INC2: begin ea = idx_reg; upd_val = idx_reg + 16'd2; upd = 1'b1; end
                M_DEC1: begin upd_val = idx_reg - 16'd1; ea = upd_val; upd = 1'b1; end
                M_DEC2: begin upd_val = idx_reg - 16'd2; ea = upd_val; upd = 1'b1; end
                M_ZERO: ea = idx_reg;
                M_B:    ea = idx_reg + sext8(b);
                M_A:    ea = idx_reg + sext8(a);
                M_N8:   ea = idx_reg + sext8(ext[7:0]);
                M_N16:  ea = idx_reg + ext;
                M_D:    ea = idx_reg + {a, b};
                M_PC8:  ea = pc + 16'd1 + sext8(ext[7:0]);
                M_PC16: ea = pc + 16'd2 + ext;
                M_EXT:  begin ea = ext; ind = 1'b1; end
                default: begin bad = 1'b1; ind = 1'b0; end
            endcase
        end
    end
endmodule

// File: rtl/jtkcpu_idxctl.sv
// jtkcpu_idxctl: indexed-addressing sequencer fetching extension bytes and indirect pointers
module jtkcpu_idxctl
    import jtkcpu_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] idx_reg,
    input  logic [15:0] pc,
    output logic [1:0]  idx_sel,
    output logic        rd,
    output logic [15:0] addr,
    output logic        pc_inc,
    output logic [15:0] ea,
    output logic        upd,
    output logic [15:0] upd_val,
    output logic        busy,
    output logic        done,
    output logic        bad
);
    state_t      st;
    logic        ph, upd_pend;
    logic [7:0]  pb, hi;
    logic [15:0] ext, ofs_ea, ofs_uv;
    logic        ofs_upd, ofs_ind, ofs_bad;
    assign idx_sel = pb[6:5];
    jtkcpu_idx_ofs u_ofs (
        .pb(pb), .a(a), .b(b), .idx_reg(idx_reg), .pc(pc), .ext(ext),
        .ea(ofs_ea), .upd_val(ofs_uv), .upd(ofs_upd), .ind(ofs_ind), .bad(ofs_bad)
    );
    // every bus byte: phase 0 holds rd/addr, phase 1 captures din
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            ph <= 1'b0;
            pb <= '0;
            hi <= '0;
            ext <= '0;
            upd_pend <= 1'b0;
            rd <= 1'b0;
            addr <= '0;
            pc_inc <= 1'b0;
            ea <= '0;
            upd <= 1'b0;
            upd_val <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bad <= 1'b0;
        end else if (cen) begin
            pc_inc <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    pb <= din;
                    busy <= 1'b1;
                    ph <= 1'b0;
                    rd <= ext_len(din) != 2'd0;
                    addr <= pc;
                    st <= ext_len(din) == 2'd2 ? EXT_HI : ext_len(din) == 2'd1 ? EXT_LO : CALC;
                end
                EXT_HI: if (!ph) begin
                    ph <= 1'b1;
                    rd <= 1'b0;
                end else begin
                    ph <= 1'b0;
                    ext[15:8] <= din;
                    pc_inc <= 1'b1;
                    rd <= 1'b1;
                    addr <= pc + 16'd1;
                    st <= EXT_LO;
                end
                EXT_LO: if (!ph) begin
                    ph <= 1'b1;
                    rd <= 1'b0;
                end else begin
                    ph <= 1'b0;
                    ext[7:0] <= din;
                    pc_inc <= 1'b1;
                    st <= CALC;
                end
                CALC: begin
                    upd_val <= ofs_uv;
                    upd_pend <= ofs_upd;
                    if (ofs_ind) begin
                        addr <= ofs_ea;
                        rd <= 1'b1;
                        st <= IND_HI;
                    end else begin
                        ea <= ofs_ea;
                        done <= 1'b1;
                        upd <= ofs_upd;
                        bad <= ofs_bad;
                        st <= FIN;
                    end
                end
                IND_HI: if (!ph) begin
                    ph <= 1'b1;
                    rd <= 1'b0;
                end else begin
                    ph <= 1'b0;
                    hi <= din;
                    rd <= 1'b1;
                    addr <= addr + 16'd1;
                    st <= IND_LO;
                end
                IND_LO: if (!ph) begin
                    ph <= 1'b1;
                    rd <= 1'b0;
                end else begin
                    ph <= 1'b0;
                    ea <= {hi, din};
                    done <= 1'b1;
                    upd <= upd_pend;
                    st <= FIN;
                end
                FIN: begin
                    done <= 1'b0;
                    upd <= 1'b0;
                    bad <= 1'b0;
                    busy <= 1'b0;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkcpu_idxctl.sv
// tb_jtkcpu_idxctl: directed checks of the indexed-addressing sequencer
module tb_jtkcpu_idxctl;
    logic        rst = 1'b1, clk = 1'b0, cen = 1'b1, start = 1'b0;
    logic [7:0]  pb_drv = '0, rdata = '0, a = '0, b = '0;
    logic [15:0] pc = 16'h0100, rx = '0, ry = '0, ru = '0, rs = '0;
    logic [7:0]  din;
    logic [15:0] idx_reg, addr, ea, upd_val;
    logic [1:0]  idx_sel;
    logic        rd, pc_inc, upd, busy, done, bad;
    logic [7:0]  mem [0:65535];
    int          n_chk = 0, n_fail = 0;
    int          lat, npc, nrd, ndone;
    logic [15:0] a0, eav, uvv;
    logic        updv, badv, busy1;

    jtkcpu_idxctl dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .din(din), .a(a), .b(b),
        .idx_reg(idx_reg), .pc(pc), .idx_sel(idx_sel), .rd(rd), .addr(addr),
        .pc_inc(pc_inc), .ea(ea), .upd(upd), .upd_val(upd_val), .busy(busy),
        .done(done), .bad(bad)
    );

    always #5 clk = ~clk;
    assign din = start ? pb_drv : rdata;
    assign idx_reg = idx_sel == 2'd0 ? rx : idx_sel == 2'd1 ? ry : idx_sel == 2'd2 ? ru : rs;
    always @(posedge clk) if (cen && rd) rdata <= mem[addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one transaction; optional second start while busy, optional cen=0 stall after first cycle
    task automatic txn(input logic [7:0] p, input bit restart, input int hold);
        @(negedge clk);
        pb_drv = p;
        start = 1'b1;
        lat = 0; npc = 0; nrd = 0; a0 = '0; eav = '0; uvv = '0; updv = 1'b0; badv = 1'b0; busy1 = 1'b0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk);
            start = restart && i == 1;
            pb_drv = restart ? 8'hBF : p;
            if (i == 1) begin
                busy1 = busy;
                if (hold > 0) begin
                    cen = 1'b0;
                    repeat (hold) @(negedge clk);
                    chk("freeze_rd", {31'd0, rd}, 32'd1);
                    chk("freeze_addr", {16'd0, addr}, 32'h0100);
                    cen = 1'b1;
                end
            end
            if (rd) begin
                if (nrd == 0) a0 = addr;
                nrd++;
            end
            if (pc_inc) npc++;
            if (done) begin
                lat = i; eav = ea; updv = upd; uvv = upd_val; badv = bad;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd", {31'd0, rd}, 32'd0);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_ea", {16'd0, ea}, 32'd0);
        rst = 1'b0;
        mem[16'h0100] = 8'h80;
        // 5-bit offset -1 on Y
        ry = 16'h1000;
        txn(8'hBF, 1'b0, 0);
        chk("o5_lat", lat, 2);
        chk("o5_ea", {16'd0, eav}, 32'h0FFF);
        chk("o5_nrd", nrd, 0);
        chk("o5_busy", {31'd0, busy1}, 32'd1);
        chk("o5_sel", {30'd0, idx_sel}, 32'd1);
        // n8,X negative
        rx = 16'h2000;
        txn(8'h08, 1'b0, 0);
        chk("n8_lat", lat, 4);
        chk("n8_ea", {16'd0, eav}, 32'h1F80);
        chk("n8_addr", {16'd0, a0}, 32'h0100);
        chk("n8_nrd", nrd, 1);
        chk("n8_pcinc", npc, 1);
        // n8,PC
        txn(8'h0C, 1'b0, 0);
        chk("pc8_lat", lat, 4);
        chk("pc8_ea", {16'd0, eav}, 32'h0081);
        // [n16] absolute indirect
        mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34;
        mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
        txn(8'h1F, 1'b0, 0);
        chk("abs_lat", lat, 10);
        chk("abs_ea", {16'd0, eav}, 32'hABCD);
        chk("abs_nrd", nrd, 4);
        chk("abs_pcinc", npc, 2);
        // n16,PC
        txn(8'h0D, 1'b0, 0);
        chk("pc16_lat", lat, 6);
        chk("pc16_ea", {16'd0, eav}, 32'h1336);
        // n16,X
        txn(8'h09, 1'b0, 0);
        chk("n16_lat", lat, 6);
        chk("n16_ea", {16'd0, eav}, 32'h3234);
        // ,U++ wraps
        ru = 16'hFFFF;
        txn(8'h41, 1'b0, 0);
        chk("inc2_lat", lat, 2);
        chk("inc2_ea", {16'd0, eav}, 32'hFFFF);
        chk("inc2_upd", {31'd0, updv}, 32'd1);
        chk("inc2_val", {16'd0, uvv}, 32'h0001);
        // ,--S wraps
        rs = 16'h0001;
        txn(8'h63, 1'b0, 0);
        chk("dec2_ea", {16'd0, eav}, 32'hFFFF);
        chk("dec2_val", {16'd0, uvv}, 32'hFFFF);
        chk("dec2_upd", {31'd0, updv}, 32'd1);
        // A,X sign-extended
        a = 8'h90;
        txn(8'h06, 1'b0, 0);
        chk("a_ea", {16'd0, eav}, 32'h1F90);
        chk("a_upd", {31'd0, updv}, 32'd0);
        // D,Y wraps to zero
        ry = 16'h1000; a = 8'hF0; b = 8'h00;
        txn(8'h2B, 1'b0, 0);
        chk("d_ea", {16'd0, eav}, 32'h0000);
        chk("d_sel", {30'd0, idx_sel}, 32'd1);
        // [,X]
        rx = 16'h1234;
        txn(8'h14, 1'b0, 0);
        chk("ind0_lat", lat, 6);
        chk("ind0_ea", {16'd0, eav}, 32'hABCD);
        // illegal modes
        txn(8'h07, 1'b0, 0);
        chk("bad7_lat", lat, 2);
        chk("bad7_bad", {31'd0, badv}, 32'd1);
        chk("bad7_ea", {16'd0, eav}, 32'd0);
        chk("bad7_upd", {31'd0, updv}, 32'd0);
        txn(8'h10, 1'b0, 0);
        chk("badi_bad", {31'd0, badv}, 32'd1);
        chk("badi_nrd", nrd, 0);
        txn(8'h04, 1'b0, 0);
        chk("zero_bad", {31'd0, badv}, 32'd0);
        chk("zero_ea", {16'd0, eav}, 32'h1234);
        // start while busy ignored
        txn(8'h0D, 1'b1, 0);
        chk("rest_lat", lat, 6);
        chk("rest_ea", {16'd0, eav}, 32'h1336);
        // cen=0 stall does not count
        mem[16'h0100] = 8'h80;
        rx = 16'h2000;
        txn(8'h08, 1'b0, 3);
        chk("frz_lat", lat, 4);
        chk("frz_ea", {16'd0, eav}, 32'h1F80);
        // reset during EXT_LO aborts without done
        @(negedge clk);
        pb_drv = 8'h08;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_rd", {31'd0, rd}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_rd", {31'd0, rd}, 32'd0);
        chk("ar_addr", {16'd0, addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ar_nodone", ndone, 0);
        chk("ar_idle", {31'd0, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
